spi_slave_rx: RTL and testbench

// SPI responder (slave) for the SPI master's MSB-first shift register (mode 0: CPOL=0, CPHA=0).

---
 rtl/spi_slave_rx.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// +--------------------------------------------------------------------------+
// | spi_slave_rx : SPI mode-0 responder, MSB-first rx/tx with valid/ack out  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_slave_rx #(
  parameter int CHAR_LENGTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [CHAR_LENGTH-1:0] tx_data,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ack,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int CNT_W = (CHAR_LENGTH > 1) ? $clog2(CHAR_LENGTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(CHAR_LENGTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_hist_q;
  logic                   ss_hist_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CHAR_LENGTH-1:0] rx_sr_q, rx_sr_d;
  logic [CHAR_LENGTH-1:0] tx_sr_q, tx_sr_d;
  logic                   reload_q, reload_d;
  logic                   done_q, done_d;
  logic [CHAR_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_n_s = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_fall   = ~ss_n_s & ss_hist_q;
  assign ss_rise   = ss_n_s & ~ss_hist_q;

  // ss_n idles high, so its synchroniser resets to 1 to avoid a false frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_n_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      reload_q    <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      reload_q    <= reload_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_ACTIVE;
          tx_sr_d   = tx_data;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          reload_d  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          reload_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[CHAR_LENGTH-2:0], mosi_s};
          if (bit_cnt_q == C_LAST_BIT) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // The fall after a completed character fetches the next reply word.
          if (reload_q) begin
            tx_sr_d  = tx_data;
            reload_d = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[CHAR_LENGTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    // An ack in the completion cycle frees the slot for the new character.
    if (done_q) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    miso_oe   = (state_q == ST_ACTIVE);
    miso      = (state_q == ST_ACTIVE) ? tx_sr_q[CHAR_LENGTH-1] : 1'b0;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    overrun   = overrun_q;
    frame_err = frame_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// +--------------------------------------------------------------------------+
// | tb_spi_slave_rx : scoreboard bench for spi_slave_rx (mode 0, 8-bit)      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave_rx;

  localparam int CL   = 8;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          miso_oe;
  logic [CL-1:0] tx_data = '0;
  logic [CL-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ack = 1'b0;
  logic          overrun;
  logic          frame_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [CL-1:0] exp_q[$];

  spi_slave_rx #(.CHAR_LENGTH(CL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits of d out on mosi, collecting miso just before each rising sclk.
  task automatic send_char(input logic [CL-1:0] d, input int nbits, input logic [CL-1:0] tx_next,
                           input bit ack_at_done, output logic [CL-1:0] mb);
    mb = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[CL-1-i];
      wait_n(HALF);
      mb[CL-1-i] = miso;
      sclk = 1'b1;
      if (i == CL - 1) begin
        tx_data = tx_next;
        if (ack_at_done) begin
          wait_n(3);
          rx_ack = 1'b1;
          wait_n(1);
          rx_ack = 1'b0;
          wait_n(HALF - 4);
        end else begin
          wait_n(HALF);
        end
      end else begin
        wait_n(HALF);
      end
      sclk = 1'b0;
    end
    wait_n(HALF);
  endtask

  task automatic start_frame();
    ss_n = 1'b0;
  endtask

  task automatic end_frame(input int exp_fe);
    int fe_cnt;
    fe_cnt = 0;
    ss_n = 1'b1;
    for (int i = 0; i < 2 * HALF; i++) begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
    end
    chk("frame_err_pulses", fe_cnt, exp_fe);
    chk("miso_oe_idle", miso_oe, 1'b0);
  endtask

  task automatic expect_rx(input string tag);
    int t;
    logic [CL-1:0] e;
    t = 0;
    while (!rx_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!rx_valid) chk({tag, "_valid_timeout"}, rx_valid, 1'b1);
    else if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      chk(tag, rx_data, e);
    end
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    wait_n(1);
    rx_ack = 1'b0;
    wait_n(1);
    chk("ack_clears_valid", rx_valid, 1'b0);
  endtask

  initial begin
    logic [CL-1:0] mb;

    wait_n(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    rst = 1'b0;
    wait_n(4);

    // Single character with reply.
    tx_data = 8'h3C;
    start_frame();
    exp_q.push_back(8'hA5);
    send_char(8'hA5, CL, 8'h00, 1'b0, mb);
    chk("t1_miso_bits", mb, 8'h3C);
    chk("t1_miso_oe", miso_oe, 1'b1);
    expect_rx("t1_rx");
    ack();
    end_frame(0);

    // Back-to-back characters, reply re-sampled at the boundary.
    tx_data = 8'h11;
    start_frame();
    exp_q.push_back(8'h12);
    send_char(8'h12, CL, 8'h22, 1'b0, mb);
    chk("t2_miso_bits0", mb, 8'h11);
    expect_rx("t2_rx0");
    ack();
    exp_q.push_back(8'h34);
    send_char(8'h34, CL, 8'h00, 1'b0, mb);
    chk("t2_miso_bits1", mb, 8'h22);
    expect_rx("t2_rx1");
    chk("t2_overrun", overrun, 1'b0);
    ack();
    end_frame(0);

    // Overrun: second character dropped while the first is unacknowledged.
    tx_data = 8'h00;
    start_frame();
    exp_q.push_back(8'h55);
    send_char(8'h55, CL, 8'h00, 1'b0, mb);
    expect_rx("t3_rx");
    send_char(8'hAA, CL, 8'h00, 1'b0, mb);
    chk("t3_rx_kept", rx_data, 8'h55);
    chk("t3_valid_kept", rx_valid, 1'b1);
    chk("t3_overrun_set", overrun, 1'b1);
    ack();
    chk("t3_overrun_clr", overrun, 1'b0);
    end_frame(0);

    // Partial character then a clean frame.
    start_frame();
    send_char(8'hF0, 5, 8'h00, 1'b0, mb);
    end_frame(1);
    chk("t4_no_valid", rx_valid, 1'b0);
    tx_data = 8'h5B;
    start_frame();
    exp_q.push_back(8'hC3);
    send_char(8'hC3, CL, 8'h00, 1'b0, mb);
    chk("t4_miso_bits", mb, 8'h5B);
    expect_rx("t4_rx");
    ack();
    end_frame(0);

    // Reset mid-frame, then a fresh frame.
    start_frame();
    exp_q.push_back(8'h66);
    send_char(8'h66, CL, 8'h00, 1'b0, mb);
    expect_rx("t5_pre");
    send_char(8'h0F, 4, 8'h00, 1'b0, mb);
    rst = 1'b1;
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    exp_q.delete();
    wait_n(1);
    chk("t5_rst_rx_data", rx_data, 8'h00);
    chk("t5_rst_rx_valid", rx_valid, 1'b0);
    chk("t5_rst_miso_oe", miso_oe, 1'b0);
    chk("t5_rst_miso", miso, 1'b0);
    chk("t5_rst_overrun", overrun, 1'b0);
    wait_n(2);
    rst = 1'b0;
    wait_n(4);
    tx_data = 8'h96;
    start_frame();
    exp_q.push_back(8'h81);
    send_char(8'h81, CL, 8'h00, 1'b0, mb);
    chk("t5_miso_bits", mb, 8'h96);
    expect_rx("t5_rx");
    ack();
    end_frame(0);

    // Completion coinciding with rx_ack.
    start_frame();
    exp_q.push_back(8'h5A);
    send_char(8'h5A, CL, 8'h00, 1'b0, mb);
    expect_rx("t6_first");
    exp_q.push_back(8'hE7);
    send_char(8'hE7, CL, 8'h00, 1'b1, mb);
    chk("t6_valid", rx_valid, 1'b1);
    chk("t6_overrun", overrun, 1'b0);
    expect_rx("t6_rx");
    ack();
    end_frame(0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
